// File: rtl/apb_pkg.sv
// Shared encodings for the AXI-Lite to APB bridge: FSM states, response codes
// and the address bit that selects between the two APB slaves.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The address MSB selects the slave: 0 = UART, 1 = TIMER.
    function automatic int unsigned decode_bit(input int unsigned addr_width);
        return addr_width - 1;
    endfunction

endpackage

// File: rtl/axi_lite_apb_bridge_if.sv
// Bus bundle for the bridge: AXI-Lite slave channels plus the APB request/response.
// slave = bridge side, master = AXI host together with the APB completer.
interface axi_lite_apb_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] S_AWADDR;
    logic                  S_AWVALID;
    logic                  S_AWREADY;
    logic [DATA_WIDTH-1:0] S_WDATA;
    logic                  S_WVALID;
    logic                  S_WREADY;
    logic [1:0]            S_BRESP;
    logic                  S_BVALID;
    logic                  S_BREADY;
    logic [ADDR_WIDTH-1:0] S_ARADDR;
    logic                  S_ARVALID;
    logic                  S_ARREADY;
    logic [DATA_WIDTH-1:0] S_RDATA;
    logic [1:0]            S_RRESP;
    logic                  S_RVALID;
    logic                  S_RREADY;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PENABLE;
    logic                  PSEL_UART;
    logic                  PSEL_TIMER;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY,
        input  S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
        output S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
        output PADDR, PWRITE, PWDATA, PENABLE, PSEL_UART, PSEL_TIMER,
        input  PREADY, PRDATA, PSLVERR
    );

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY,
        output S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
        input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
        input  PADDR, PWRITE, PWDATA, PENABLE, PSEL_UART, PSEL_TIMER,
        output PREADY, PRDATA, PSLVERR
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts APB ACCESS cycles without PREADY; expired flags the last allowed cycle.
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of stalled ACCESS cycles already seen
    assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// AXI-Lite slave to APB master bridge: one transaction at a time, round-robin
// between reads and writes, two decoded APB slaves and an ACCESS timeout.
module axi_lite_apb_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                   PCLK,
    input logic                   PRESETn,
    axi_lite_apb_bridge_if.slave  bus
);
    localparam int unsigned SEL_BIT = decode_bit(ADDR_WIDTH);

    state_t                state;
    logic                  aw_ready;
    logic                  w_ready;
    logic                  ar_ready;
    logic                  b_valid;
    logic                  r_valid;
    logic                  prefer_write;
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  penable;
    logic                  psel_uart;
    logic                  psel_timer;

    logic wr_elig;
    logic rd_elig;
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    assign wr_elig    = bus.S_AWVALID && bus.S_WVALID;
    assign rd_elig    = bus.S_ARVALID;
    assign tmo_clear  = (state != ST_ACCESS);
    assign tmo_enable = (state == ST_ACCESS) && !bus.PREADY;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // IDLE spends one cycle with READY raised; the handshake edge launches SETUP
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state        <= ST_IDLE;
            aw_ready     <= 1'b0;
            w_ready      <= 1'b0;
            ar_ready     <= 1'b0;
            b_valid      <= 1'b0;
            r_valid      <= 1'b0;
            prefer_write <= 1'b1;
            resp         <= RESP_OKAY;
            rdata        <= '0;
            paddr        <= '0;
            pwdata       <= '0;
            pwrite       <= 1'b0;
            penable      <= 1'b0;
            psel_uart    <= 1'b0;
            psel_timer   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (aw_ready || ar_ready) begin
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b0;
                        ar_ready <= 1'b0;
                        pwrite   <= aw_ready;
                        state    <= ST_SETUP;
                        if (aw_ready) begin
                            paddr      <= bus.S_AWADDR;
                            pwdata     <= bus.S_WDATA;
                            psel_uart  <= !bus.S_AWADDR[SEL_BIT];
                            psel_timer <= bus.S_AWADDR[SEL_BIT];
                        end else begin
                            paddr      <= bus.S_ARADDR;
                            psel_uart  <= !bus.S_ARADDR[SEL_BIT];
                            psel_timer <= bus.S_ARADDR[SEL_BIT];
                        end
                    end else if (wr_elig && (prefer_write || !rd_elig)) begin
                        aw_ready     <= 1'b1;
                        w_ready      <= 1'b1;
                        prefer_write <= 1'b0;
                    end else if (rd_elig) begin
                        ar_ready     <= 1'b1;
                        prefer_write <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.PREADY || tmo_expired) begin
                        psel_uart  <= 1'b0;
                        psel_timer <= 1'b0;
                        penable    <= 1'b0;
                        b_valid    <= pwrite;
                        r_valid    <= !pwrite;
                        state      <= ST_RESP;
                        if (bus.PREADY) begin
                            resp <= bus.PSLVERR ? RESP_SLVERR : RESP_OKAY;
                            if (!pwrite) begin
                                rdata <= bus.PRDATA;
                            end
                        end else begin
                            resp <= RESP_SLVERR;
                            if (!pwrite) begin
                                rdata <= '0;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if ((b_valid && bus.S_BREADY) || (r_valid && bus.S_RREADY)) begin
                        b_valid <= 1'b0;
                        r_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.S_AWREADY  = aw_ready;
    assign bus.S_WREADY   = w_ready;
    assign bus.S_ARREADY  = ar_ready;
    assign bus.S_BVALID   = b_valid;
    assign bus.S_BRESP    = resp;
    assign bus.S_RVALID   = r_valid;
    assign bus.S_RRESP    = resp;
    assign bus.S_RDATA    = rdata;
    assign bus.PADDR      = paddr;
    assign bus.PWDATA     = pwdata;
    assign bus.PWRITE     = pwrite;
    assign bus.PENABLE    = penable;
    assign bus.PSEL_UART  = psel_uart;
    assign bus.PSEL_TIMER = psel_timer;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Scoreboard bench for axi_lite_apb_bridge: randomized AXI traffic, an APB
// completer following per-transaction plans, and a response monitor.
module tb_axi_lite_apb_bridge;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    typedef struct {
        bit                wr;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     data;
        int unsigned       wt;      // PREADY low cycles before the ready cycle
        bit                err;
        logic [DW-1:0]     prdata;
    } txn_t;

    typedef struct {
        bit            wr;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } exp_t;

    logic PCLK;
    logic PRESETn;

    axi_lite_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_apb_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    txn_t apb_q[$];
    exp_t exp_q[$];
    bit   model_pref_w = 1'b1;
    bit   hold_ready   = 1'b0;
    bit   mon_active   = 1'b0;
    bit   slave_busy   = 1'b0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input int unsigned wt, input bit err, input logic [DW-1:0] prdata);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.wt = wt; t.err = err; t.prdata = prdata;
        return t;
    endfunction

    // Response implied by the completer plan: a stall of TMO or more cycles times out.
    function automatic exp_t expect_of(input txn_t t);
        exp_t e;
        e.wr    = t.wr;
        e.resp  = (t.wt >= TMO || t.err) ? 2'b10 : 2'b00;
        e.rdata = (t.wt >= TMO) ? '0 : t.prdata;
        return e;
    endfunction

    function automatic txn_t rand_txn(input bit wr);
        int unsigned wt;
        wt = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 4) : $urandom_range(0, 4);
        return mk(wr, AW'($urandom), $urandom, wt, $urandom_range(0, 7) == 0, $urandom);
    endfunction

    task automatic plan(input txn_t t, input bit push_exp);
        apb_q.push_back(t);
        if (push_exp) exp_q.push_back(expect_of(t));
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq(name, {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY, bus.S_BVALID, bus.S_RVALID,
                        bus.S_BRESP, bus.S_RRESP, bus.S_RDATA, bus.PADDR, bus.PWRITE, bus.PWDATA,
                        bus.PENABLE, bus.PSEL_UART, bus.PSEL_TIMER}, '0);
    endtask

    // Drive a write, a read, or both at once; the model decides who is served first.
    task automatic issue(input bit dw, input bit dr, input txn_t tw, input txn_t tr, input bit push_exp);
        bit w_pend = 0, r_pend = 0, w_done, r_done;
        int cyc = 0;
        if (dw && dr) begin
            if (model_pref_w) begin plan(tw, push_exp); plan(tr, push_exp); end
            else              begin plan(tr, push_exp); plan(tw, push_exp); end
        end else if (dw) begin
            plan(tw, push_exp); model_pref_w = 1'b0;
        end else if (dr) begin
            plan(tr, push_exp); model_pref_w = 1'b1;
        end
        bus.S_AWADDR = tw.addr; bus.S_WDATA = tw.data; bus.S_ARADDR = tr.addr;
        bus.S_AWVALID = dw; bus.S_WVALID = dw; bus.S_ARVALID = dr;
        w_done = !dw; r_done = !dr;
        while (!(w_done && r_done) && cyc < 400) begin
            @(posedge PCLK); #1;
            cyc++;
            if (w_pend) begin
                w_pend = 0; w_done = 1; bus.S_AWVALID = 0; bus.S_WVALID = 0;
                check_eq("aw_ready_pulse", {bus.S_AWREADY, bus.S_WREADY}, 2'b00);
                check_eq("setup_after_w_accept", {bus.PSEL_UART | bus.PSEL_TIMER, bus.PENABLE}, 2'b10);
            end else if (!w_done && bus.S_AWREADY) begin
                check_eq("w_ready_with_aw", bus.S_WREADY, 1'b1);
                w_pend = 1;
            end
            if (r_pend) begin
                r_pend = 0; r_done = 1; bus.S_ARVALID = 0;
                check_eq("ar_ready_pulse", bus.S_ARREADY, 1'b0);
                check_eq("setup_after_r_accept", {bus.PSEL_UART | bus.PSEL_TIMER, bus.PENABLE}, 2'b10);
            end else if (!r_done && bus.S_ARREADY) begin
                r_pend = 1;
            end
        end
        bus.S_AWVALID = 0; bus.S_WVALID = 0; bus.S_ARVALID = 0;
        check_eq("accept_done", {w_done, r_done}, 2'b11);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (cyc < 300 && !(exp_q.size() == 0 && apb_q.size() == 0 && !mon_active && !slave_busy)) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        check_eq("drain_idle", {exp_q.size() == 0, apb_q.size() == 0, !mon_active, !slave_busy}, 4'hF);
    endtask

    // APB completer: follows the next plan, checks SETUP/ACCESS signalling.
    initial begin
        txn_t t;
        logic [AW+DW+3:0] snap;
        bit aborted;
        bus.PREADY = 0; bus.PRDATA = '0; bus.PSLVERR = 0;
        forever begin
            @(posedge PCLK); #1;
            if (!PRESETn) begin
                bus.PREADY = 0; slave_busy = 0;
            end else if ((bus.PSEL_UART || bus.PSEL_TIMER) && !bus.PENABLE) begin
                slave_busy = 1;
                aborted = 0;
                if (apb_q.size() == 0) begin
                    check_eq("apb_unplanned", {bus.PSEL_UART, bus.PSEL_TIMER}, 2'b00);
                    t = mk(0, '0, '0, 0, 0, '0);
                end else begin
                    t = apb_q.pop_front();
                    check_eq("setup_addr", bus.PADDR, t.addr);
                    check_eq("setup_write", bus.PWRITE, t.wr);
                    if (t.wr) check_eq("setup_wdata", bus.PWDATA, t.data);
                    check_eq("setup_sel", {bus.PSEL_UART, bus.PSEL_TIMER}, t.addr[AW-1] ? 2'b01 : 2'b10);
                end
                snap = {1'b1, bus.PSEL_UART, bus.PSEL_TIMER, bus.PADDR, bus.PWRITE, bus.PWDATA};
                for (int k = 0; k < int'(TMO); k++) begin
                    @(posedge PCLK); #1;
                    if (!PRESETn) begin aborted = 1; break; end
                    check_eq("access_hold", {bus.PENABLE, bus.PSEL_UART, bus.PSEL_TIMER, bus.PADDR,
                                             bus.PWRITE, bus.PWDATA}, snap);
                    if (k == int'(t.wt)) begin
                        bus.PREADY = 1; bus.PRDATA = t.prdata; bus.PSLVERR = t.err;
                        break;
                    end
                    bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom_range(0, 1));
                end
                if (!aborted) begin
                    @(posedge PCLK); #1;
                    bus.PREADY = 0; bus.PSLVERR = 0;
                    if (PRESETn) begin
                        check_eq("sel_drop_after_access", {bus.PSEL_UART, bus.PSEL_TIMER, bus.PENABLE}, 3'b000);
                        check_eq("resp_latency", t.wr ? bus.S_BVALID : bus.S_RVALID, 1'b1);
                    end
                end
                bus.PREADY = 0;
                slave_busy = 0;
            end else begin
                check_eq("apb_idle", {bus.PSEL_UART, bus.PSEL_TIMER, bus.PENABLE}, 3'b000);
            end
        end
    end

    // Response monitor: pops the scoreboard on the first VALID cycle, then checks stability.
    initial begin
        exp_t cur;
        logic [DW+3:0] held;
        int hold_cnt = 0;
        bit rdy_drv = 0;
        bus.S_BREADY = 0; bus.S_RREADY = 0;
        forever begin
            @(posedge PCLK); #1;
            if (!PRESETn) begin
                mon_active = 0; rdy_drv = 0; bus.S_BREADY = 0; bus.S_RREADY = 0;
            end else begin
                if (rdy_drv) begin
                    rdy_drv = 0; bus.S_BREADY = 0; bus.S_RREADY = 0; mon_active = 0;
                    check_eq("valid_drop_after_hs", {bus.S_BVALID, bus.S_RVALID}, 2'b00);
                end
                if (bus.S_BVALID || bus.S_RVALID) begin
                    if (!mon_active) begin
                        mon_active = 1;
                        hold_cnt = $urandom_range(0, 2);
                        if (exp_q.size() == 0) begin
                            check_eq("unexpected_resp", {bus.S_BVALID, bus.S_RVALID}, 2'b00);
                        end else begin
                            cur = exp_q.pop_front();
                            check_eq("resp_type", {bus.S_BVALID, bus.S_RVALID}, cur.wr ? 2'b10 : 2'b01);
                            check_eq("resp_code", cur.wr ? bus.S_BRESP : bus.S_RRESP, cur.resp);
                            if (!cur.wr) check_eq("rdata", bus.S_RDATA, cur.rdata);
                        end
                        held = {bus.S_BVALID, bus.S_RVALID, bus.S_RVALID ? bus.S_RRESP : bus.S_BRESP, bus.S_RDATA};
                    end else begin
                        check_eq("resp_stable", {bus.S_BVALID, bus.S_RVALID,
                                 bus.S_RVALID ? bus.S_RRESP : bus.S_BRESP, bus.S_RDATA}, held);
                    end
                    if (!hold_ready) begin
                        if (hold_cnt > 0) hold_cnt--;
                        else begin
                            rdy_drv = 1; bus.S_BREADY = bus.S_BVALID; bus.S_RREADY = bus.S_RVALID;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t tz, tw, tr;
        int cyc;
        int sel;
        tz = mk(0, '0, '0, 0, 0, '0);
        PRESETn = 0;
        bus.S_AWADDR = '0; bus.S_AWVALID = 0; bus.S_WDATA = '0; bus.S_WVALID = 0;
        bus.S_ARADDR = '0; bus.S_ARVALID = 0;
        repeat (2) @(posedge PCLK);
        #1 check_reset_outputs("reset_state");
        @(negedge PCLK) PRESETn = 1;
        @(posedge PCLK); #1;

        // Directed: UART write, TIMER read with wait states, round-robin pairs
        issue(1, 0, mk(1, 10'h004, 32'hA5A5A5A5, 0, 0, '0), tz, 1); wait_idle();
        issue(0, 1, tz, mk(0, 10'h204, '0, 3, 0, 32'h12345678), 1); wait_idle();
        for (int i = 0; i < 2; i++) begin
            issue(1, 1, rand_txn(1), rand_txn(0), 1); wait_idle();
        end

        // Timeout boundaries and slave error
        issue(0, 1, tz, mk(0, 10'h310, '0, 40, 0, 32'hDEADBEEF), 1); wait_idle();
        issue(0, 1, tz, mk(0, 10'h010, '0, TMO - 1, 0, 32'h0BADF00D), 1); wait_idle();
        issue(1, 0, mk(1, 10'h020, 32'h11223344, 1, 1, '0), tz, 1); wait_idle();

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            tw = rand_txn(1); tr = rand_txn(0);
            issue(sel < 4 || sel >= 8, sel >= 4, tw, tr, 1);
            wait_idle();
        end

        // Reset during ACCESS of a write: no response, write preference restored
        issue(1, 0, mk(1, 10'h1F0, 32'hCAFEF00D, 40, 0, '0), tz, 0);
        repeat (3) @(posedge PCLK);
        #3 PRESETn = 0;
        #1 check_reset_outputs("reset_in_access");
        apb_q.delete(); exp_q.delete();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1;
        model_pref_w = 1'b1;
        @(posedge PCLK); #1;
        issue(1, 1, rand_txn(1), rand_txn(0), 1); wait_idle();

        // Held read response with RREADY low, then reset while waiting
        hold_ready = 1;
        issue(0, 1, tz, mk(0, 10'h2A8, '0, 1, 0, 32'h5EED5EED), 1);
        cyc = 0;
        while (cyc < 50 && !mon_active) begin @(posedge PCLK); #1; cyc++; end
        check_eq("rvalid_held", bus.S_RVALID, 1'b1);
        repeat (4) @(posedge PCLK);
        #3 PRESETn = 0;
        #1 check_reset_outputs("reset_in_resp");
        exp_q.delete(); apb_q.delete();
        hold_ready = 0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1;
        model_pref_w = 1'b1;
        @(posedge PCLK); #1;
        issue(1, 1, rand_txn(1), rand_txn(0), 1); wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
